// File: rtl/board_editor.sv
// Editable ROWS x COLS Game of Life board with a 2-D button-driven cursor,
// row writes / cell toggles, a row-per-cycle clear sweep and a bulk load.
//
// state   | meaning
// S_IDLE  | edits and cursor moves accepted when enabled
// S_CLEAR | zeroing row clr_ptr each cycle; buttons dropped, cursor frozen
module board_editor #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int WRAP = 0,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_center,
  input  logic                 clear_req,
  input  logic                 mode,
  input  logic [COLS-1:0]      cell_inputs,
  input  logic                 load_valid,
  input  logic [ROWS*COLS-1:0] load_board,
  output logic [ROWS*COLS-1:0] output_board,
  output logic [RW-1:0]        row_idx,
  output logic [CW-1:0]        col_idx,
  output logic                 busy
);

  localparam int N = ROWS * COLS;
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [N-1:0] ROW_ONES = {{(N-COLS){1'b0}}, {COLS{1'b1}}};
  localparam logic [N-1:0] BIT_ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        state;
  logic [RW-1:0] clr_ptr;
  logic          prev_up, prev_down, prev_left, prev_right, prev_center, prev_clr;
  logic          ev_up, ev_down, ev_left, ev_right, ev_center, ev_clr;
  logic [RW-1:0] row_nxt;
  logic [CW-1:0] col_nxt;
  int            row_off, clr_off, cell_off;

  assign ev_up     = btn_up     & ~prev_up;
  assign ev_down   = btn_down   & ~prev_down;
  assign ev_left   = btn_left   & ~prev_left;
  assign ev_right  = btn_right  & ~prev_right;
  assign ev_center = btn_center & ~prev_center;
  assign ev_clr    = clear_req  & ~prev_clr;

  always_comb begin
    row_off  = int'(row_idx) * COLS;
    clr_off  = int'(clr_ptr) * COLS;
    cell_off = row_off + int'(col_idx);
  end

  // Opposing presses in the same cycle cancel on that axis.
  always_comb begin
    row_nxt = row_idx;
    col_nxt = col_idx;
    if (ev_up && !ev_down)
      row_nxt = (row_idx == '0) ? ((WRAP != 0) ? ROW_MAX : row_idx) : row_idx - RW'(1);
    else if (ev_down && !ev_up)
      row_nxt = (row_idx == ROW_MAX) ? ((WRAP != 0) ? '0 : row_idx) : row_idx + RW'(1);
    if (ev_left && !ev_right)
      col_nxt = (col_idx == '0) ? ((WRAP != 0) ? COL_MAX : col_idx) : col_idx - CW'(1);
    else if (ev_right && !ev_left)
      col_nxt = (col_idx == COL_MAX) ? ((WRAP != 0) ? '0 : col_idx) : col_idx + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      clr_ptr      <= '0;
      busy         <= 1'b0;
      output_board <= '0;
      row_idx      <= '0;
      col_idx      <= '0;
      prev_up      <= 1'b0;
      prev_down    <= 1'b0;
      prev_left    <= 1'b0;
      prev_right   <= 1'b0;
      prev_center  <= 1'b0;
      prev_clr     <= 1'b0;
    end else begin
      prev_up     <= btn_up;
      prev_down   <= btn_down;
      prev_left   <= btn_left;
      prev_right  <= btn_right;
      prev_center <= btn_center;
      prev_clr    <= clear_req;

      if (load_valid) begin
        output_board <= load_board;
        state        <= S_IDLE;
        busy         <= 1'b0;
        clr_ptr      <= '0;
      end else if (state == S_CLEAR) begin
        output_board <= output_board & ~(ROW_ONES << clr_off);
        if (clr_ptr == ROW_MAX) begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          clr_ptr <= '0;
        end else begin
          clr_ptr <= clr_ptr + RW'(1);
        end
      end else if (enable && ev_clr) begin
        state   <= S_CLEAR;
        busy    <= 1'b1;
        clr_ptr <= '0;
      end else if (enable) begin
        // Edits address the cursor as it was before this cycle's move.
        if (ev_center) begin
          if (mode)
            output_board <= output_board ^ (BIT_ONE << cell_off);
          else
            output_board <= (output_board & ~(ROW_ONES << row_off)) |
                            ({{(N-COLS){1'b0}}, cell_inputs} << row_off);
        end
        row_idx <= row_nxt;
        col_idx <= col_nxt;
      end
    end
  end

endmodule

// File: tb/tb_board_editor.sv
// Directed bench for board_editor: a saturating 16x16 instance plus a wrapping
// instance on the same inputs for the edge-wrap behaviour.
module tb_board_editor;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int N = ROWS * COLS;

  logic clk, rst_n, enable, mode, clear_req, load_valid;
  logic btn_up, btn_down, btn_left, btn_right, btn_center;
  logic [COLS-1:0] cell_inputs;
  logic [N-1:0]    load_board;
  logic [N-1:0]    board, wboard;
  logic [3:0]      row_idx, col_idx, wrow, wcol;
  logic            busy, wbusy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] ones;

  board_editor #(.ROWS(ROWS), .COLS(COLS), .WRAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center),
    .clear_req(clear_req), .mode(mode), .cell_inputs(cell_inputs),
    .load_valid(load_valid), .load_board(load_board),
    .output_board(board), .row_idx(row_idx), .col_idx(col_idx), .busy(busy)
  );

  board_editor #(.ROWS(ROWS), .COLS(COLS), .WRAP(1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center),
    .clear_req(clear_req), .mode(mode), .cell_inputs(cell_inputs),
    .load_valid(load_valid), .load_board(load_board),
    .output_board(wboard), .row_idx(wrow), .col_idx(wcol), .busy(wbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // b = {up, down, left, right, center}
  task automatic set_btns(input logic [4:0] b);
    {btn_up, btn_down, btn_left, btn_right, btn_center} = b;
  endtask

  task automatic pulse(input logic [4:0] b);
    set_btns(b);
    tick();
    set_btns(5'b0);
    tick();
  endtask

  task automatic do_reset;
    set_btns(5'b0);
    clear_req = 0; load_valid = 0; load_board = '0;
    enable = 1; mode = 0; cell_inputs = '0;
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset;
    set_btns(5'b0);
    clear_req = 0; load_valid = 0; load_board = '0;
    enable = 1; mode = 0; cell_inputs = '0;
    rst_n = 0;
    #2;
    n_cmp++; if (board !== '0) begin n_bad++; $display("FAIL reset_board got=%h want=0", board); end
    n_cmp++; if (row_idx !== 4'd0 || col_idx !== 4'd0) begin n_bad++; $display("FAIL reset_cursor got=(%0d,%0d) want=(0,0)", row_idx, col_idx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_row_write;
    do_reset();
    cell_inputs = 16'hA5A5;
    repeat (3) pulse(5'b01000);
    pulse(5'b00001);
    n_cmp++; if (row_idx !== 4'd3) begin n_bad++; $display("FAIL row_write_row got=%0d want=3", row_idx); end
    n_cmp++; if (board !== (N'(16'hA5A5) << 48)) begin n_bad++; $display("FAIL row_write_board got=%h want=%h", board, N'(16'hA5A5) << 48); end
  endtask

  task automatic test_wrap;
    do_reset();
    pulse(5'b00100);
    n_cmp++; if (col_idx !== 4'd0) begin n_bad++; $display("FAIL sat_left got=%0d want=0", col_idx); end
    n_cmp++; if (wcol !== 4'd15) begin n_bad++; $display("FAIL wrap_left got=%0d want=15", wcol); end
    pulse(5'b10000);
    n_cmp++; if (row_idx !== 4'd0) begin n_bad++; $display("FAIL sat_up got=%0d want=0", row_idx); end
    n_cmp++; if (wrow !== 4'd15) begin n_bad++; $display("FAIL wrap_up got=%0d want=15", wrow); end
    pulse(5'b01010);
    n_cmp++; if (row_idx !== 4'd1 || col_idx !== 4'd1) begin n_bad++; $display("FAIL sat_diag got=(%0d,%0d) want=(1,1)", row_idx, col_idx); end
    n_cmp++; if (wrow !== 4'd0 || wcol !== 4'd0) begin n_bad++; $display("FAIL wrap_diag got=(%0d,%0d) want=(0,0)", wrow, wcol); end
    pulse(5'b11000);
    n_cmp++; if (row_idx !== 4'd1) begin n_bad++; $display("FAIL up_down_cancel got=%0d want=1", row_idx); end
  endtask

  task automatic test_saturate;
    do_reset();
    repeat (20) pulse(5'b00010);
    n_cmp++; if (col_idx !== 4'd15) begin n_bad++; $display("FAIL sat_right got=%0d want=15", col_idx); end
    repeat (17) pulse(5'b01000);
    n_cmp++; if (row_idx !== 4'd15) begin n_bad++; $display("FAIL sat_down got=%0d want=15", row_idx); end
  endtask

  task automatic test_toggle;
    do_reset();
    mode = 1;
    repeat (2) pulse(5'b01000);
    repeat (5) pulse(5'b00010);
    pulse(5'b00001);
    n_cmp++; if (board !== (N'(1) << 37)) begin n_bad++; $display("FAIL toggle_on got=%h want=bit37", board); end
    pulse(5'b00001);
    n_cmp++; if (board !== '0) begin n_bad++; $display("FAIL toggle_off got=%h want=0", board); end
    pulse(5'b00011);
    n_cmp++; if (board !== (N'(1) << 37)) begin n_bad++; $display("FAIL toggle_move_board got=%h want=bit37", board); end
    n_cmp++; if (col_idx !== 4'd6) begin n_bad++; $display("FAIL toggle_move_col got=%0d want=6", col_idx); end
  endtask

  task automatic test_enable_off;
    do_reset();
    cell_inputs = 16'hFFFF;
    enable = 0;
    pulse(5'b01000);
    pulse(5'b00001);
    clear_req = 1; tick(); clear_req = 0; tick();
    n_cmp++; if (row_idx !== 4'd0) begin n_bad++; $display("FAIL disabled_move got=%0d want=0", row_idx); end
    n_cmp++; if (board !== '0 || busy !== 1'b0) begin n_bad++; $display("FAIL disabled_edit got=%h busy=%b want=0", board, busy); end
    load_board = ones; load_valid = 1; tick(); load_valid = 0;
    n_cmp++; if (board !== ones) begin n_bad++; $display("FAIL disabled_load got=%h want=all ones", board); end
    enable = 1;
  endtask

  task automatic test_clear;
    logic [N-1:0] exp;
    do_reset();
    cell_inputs = 16'hFFFF;
    load_board = ones; load_valid = 1; tick(); load_valid = 0;
    n_cmp++; if (board !== ones) begin n_bad++; $display("FAIL load_ones got=%h want=all ones", board); end
    clear_req = 1; tick();
    n_cmp++; if (busy !== 1'b1 || board !== ones) begin n_bad++; $display("FAIL clear_start busy=%b board=%h want busy=1 all ones", busy, board); end
    for (int k = 0; k < ROWS; k++) begin
      if (k == 2) set_btns(5'b01001);
      if (k == 4) set_btns(5'b0);
      if (k == 6) clear_req = 0;
      if (k == 8) clear_req = 1;
      tick();
      exp = ones << ((k + 1) * COLS);
      n_cmp++; if (board !== exp) begin n_bad++; $display("FAIL clear_row%0d got=%h want=%h", k, board, exp); end
      n_cmp++; if (busy !== (k < ROWS - 1)) begin n_bad++; $display("FAIL clear_busy%0d got=%b want=%b", k, busy, k < ROWS - 1); end
    end
    clear_req = 0;
    tick();
    n_cmp++; if (busy !== 1'b0 || board !== '0) begin n_bad++; $display("FAIL clear_done busy=%b board=%h want 0", busy, board); end
    n_cmp++; if (row_idx !== 4'd0) begin n_bad++; $display("FAIL clear_frozen got=%0d want=0", row_idx); end
  endtask

  task automatic test_load_abort;
    logic [N-1:0] pat;
    pat = {8{32'hDEADBEEF}};
    do_reset();
    load_board = ones; load_valid = 1; tick(); load_valid = 0;
    clear_req = 1; tick();
    repeat (4) tick();
    n_cmp++; if (board !== (ones << 64) || busy !== 1'b1) begin n_bad++; $display("FAIL abort_pre got=%h busy=%b", board, busy); end
    load_board = pat; load_valid = 1; tick(); load_valid = 0;
    n_cmp++; if (board !== pat || busy !== 1'b0) begin n_bad++; $display("FAIL abort_load got=%h busy=%b want=%h busy=0", board, busy, pat); end
    repeat (3) tick();
    n_cmp++; if (board !== pat || busy !== 1'b0) begin n_bad++; $display("FAIL abort_after got=%h busy=%b want=%h busy=0", board, busy, pat); end
    clear_req = 0;
    tick();
  endtask

  task automatic test_hold;
    do_reset();
    btn_down = 1;
    repeat (10) tick();
    btn_down = 0;
    tick();
    n_cmp++; if (row_idx !== 4'd1) begin n_bad++; $display("FAIL hold_single got=%0d want=1", row_idx); end
  endtask

  task automatic test_async_reset;
    do_reset();
    repeat (2) pulse(5'b01010);
    load_board = ones; load_valid = 1; tick(); load_valid = 0;
    clear_req = 1; tick();
    repeat (3) tick();
    #2 rst_n = 0;
    #1;
    n_cmp++; if (board !== '0 || busy !== 1'b0) begin n_bad++; $display("FAIL async_board got=%h busy=%b want 0", board, busy); end
    n_cmp++; if (row_idx !== 4'd0 || col_idx !== 4'd0) begin n_bad++; $display("FAIL async_cursor got=(%0d,%0d) want=(0,0)", row_idx, col_idx); end
    clear_req = 0;
    tick();
    rst_n = 1;
    tick();
    n_cmp++; if (board !== '0 || busy !== 1'b0) begin n_bad++; $display("FAIL async_after got=%h busy=%b want 0", board, busy); end
  endtask

  initial begin
    ones = '1;
    test_reset();
    test_row_write();
    test_wrap();
    test_saturate();
    test_toggle();
    test_enable_off();
    test_clear();
    test_load_abort();
    test_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
